// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the DIV/DIVU sequencer.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIXUP,
    DONE
  } div_state_t;

  localparam int unsigned DIV_BYTE_N = 8;
  localparam int unsigned DIV_WORD_N = 16;

endpackage

// File: rtl/div_sequencer_divu_iter.sv
// Iterative unsigned restoring divider, one quotient bit per step.
// Byte mode keeps its operands right-aligned in the 16-bit registers.
module divu_iter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        load,
  input  logic        wide,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  input  logic        step,
  output logic [15:0] quotient,
  output logic [15:0] remainder
);

  logic [15:0] pr;
  logic [15:0] q;
  logic [15:0] dvs;
  logic        wide_r;
  logic        msb;
  logic [16:0] trial;
  logic [15:0] diff;
  logic        fits;

  // Trial subtraction of the shifted partial remainder against the divisor
  always_comb begin
    msb   = wide_r ? q[15] : q[7];
    trial = {pr, msb};
    fits  = trial >= {1'b0, dvs};
    diff  = trial[15:0] - dvs;
  end

  // Operand load and one restoring step per enabled cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pr     <= '0;
      q      <= '0;
      dvs    <= '0;
      wide_r <= 1'b0;
    end else if (ce) begin
      if (load) begin
        wide_r <= wide;
        dvs    <= wide ? divisor : {8'h00, divisor[7:0]};
        pr     <= wide ? dividend[31:16] : {8'h00, dividend[15:8]};
        q      <= wide ? dividend[15:0] : {8'h00, dividend[7:0]};
      end else if (step) begin
        pr <= fits ? diff : trial[15:0];
        q  <= wide_r ? {q[14:0], fits} : {8'h00, q[6:0], fits};
      end
    end
  end

  assign quotient  = q;
  assign remainder = pr;

endmodule

// File: rtl/div_sequencer.sv
// DIV/DIVU controller: sign handling, overflow detection and sequencing
// of the unsigned divider core for byte (16/8) and word (32/16) forms.
module div_sequencer
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        req,
  input  logic        op_wide,
  input  logic        op_signed,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        div_error,
  output logic [15:0] quot,
  output logic [15:0] rem
);

  div_state_t  state, state_nx;
  logic        wide_r, sgn_r, dvd_neg_r, dvs_neg_r;
  logic [15:0] dvs_mag_r;
  logic [3:0]  cnt;
  logic        dvd_neg_in, dvs_neg_in;
  logic [31:0] dvd_mag_in;
  logic [15:0] dvs_mag_in;
  logic        accept, pre_err, step;
  logic [15:0] iq, ir;
  logic        neg_q, fix_err;
  logic [15:0] q_lim, q_fix, r_fix;

  // Operand magnitudes from the raw inputs; the core register is the input latch
  always_comb begin
    dvd_neg_in = op_signed & (op_wide ? dividend[31] : dividend[15]);
    dvs_neg_in = op_signed & (op_wide ? divisor[15] : divisor[7]);
    if (op_wide) begin
      dvd_mag_in = dvd_neg_in ? -dividend : dividend;
      dvs_mag_in = dvs_neg_in ? -divisor : divisor;
    end else begin
      dvd_mag_in = {16'h0000, (dvd_neg_in ? -dividend[15:0] : dividend[15:0])};
      dvs_mag_in = {8'h00, (dvs_neg_in ? -divisor[7:0] : divisor[7:0])};
    end
  end

  // PREP both checks the high half and takes the first quotient bit, so RUN
  // covers the remaining N-1 bits and done lands at ce-cycle N+2.
  always_comb begin
    accept  = (state == IDLE) & req;
    pre_err = (ir >= dvs_mag_r);
    step    = ((state == PREP) & ~pre_err) | (state == RUN);
  end

  // Sign application and signed range check on the unsigned result
  always_comb begin
    neg_q   = dvd_neg_r ^ dvs_neg_r;
    q_lim   = wide_r ? 16'h7FFF : 16'h007F;
    if (neg_q) q_lim = q_lim + 16'd1;
    fix_err = sgn_r & (iq > q_lim);
    q_fix   = neg_q ? -iq : iq;
    r_fix   = dvd_neg_r ? -ir : ir;
    if (!wide_r) begin
      q_fix[15:8] = '0;
      r_fix[15:8] = '0;
    end
  end

  divu_iter u_iter (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .load      (accept),
    .wide      (op_wide),
    .dividend  (dvd_mag_in),
    .divisor   (dvs_mag_in),
    .step      (step),
    .quotient  (iq),
    .remainder (ir)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else if (ce)  state <= state_nx;
  end

  // Next-state and status decode
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (req) state_nx = PREP;
      PREP: begin
        busy     = 1'b1;
        state_nx = pre_err ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == 4'd1) state_nx = FIXUP;
      end
      FIXUP: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand attributes, iteration counter and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wide_r    <= 1'b0;
      sgn_r     <= 1'b0;
      dvd_neg_r <= 1'b0;
      dvs_neg_r <= 1'b0;
      dvs_mag_r <= '0;
      cnt       <= '0;
      div_error <= 1'b0;
      quot      <= '0;
      rem       <= '0;
    end else if (ce) begin
      case (state)
        IDLE: if (req) begin
          wide_r    <= op_wide;
          sgn_r     <= op_signed;
          dvd_neg_r <= dvd_neg_in;
          dvs_neg_r <= dvs_neg_in;
          dvs_mag_r <= dvs_mag_in;
          div_error <= 1'b0;
          quot      <= '0;
          rem       <= '0;
        end
        PREP: begin
          if (pre_err) div_error <= 1'b1;
          else cnt <= wide_r ? 4'(DIV_WORD_N - 1) : 4'(DIV_BYTE_N - 1);
        end
        RUN: cnt <= cnt - 4'd1;
        FIXUP: begin
          div_error <= fix_err;
          quot      <= fix_err ? '0 : q_fix;
          rem       <= fix_err ? '0 : r_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with an arithmetic reference model.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, ce, req, op_wide, op_signed;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy, done, div_error;
  logic [15:0] quot, rem;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        err;
    int unsigned lat;
    int unsigned start;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cecnt    = 0;
  int          ce_mode  = 0;
  logic        done_q   = 1'b0;
  exp_t        mon_e;

  div_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .req       (req),
    .op_wide   (op_wide),
    .op_signed (op_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_error (div_error),
    .quot      (quot),
    .rem       (rem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ce) cecnt <= cecnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero
  function automatic exp_t model(input logic w, input logic s,
                                 input logic [31:0] dvd, input logic [15:0] dvs);
    exp_t   e;
    int     n;
    longint d, v, dm, vm, q, r, lim;
    n = w ? 16 : 8;
    if (w) begin
      d = s ? longint'($signed(dvd)) : longint'(dvd);
      v = s ? longint'($signed(dvs)) : longint'(dvs);
    end else begin
      d = s ? longint'($signed(dvd[15:0])) : longint'(dvd[15:0]);
      v = s ? longint'($signed(dvs[7:0])) : longint'(dvs[7:0]);
    end
    dm = (d < 0) ? -d : d;
    vm = (v < 0) ? -v : v;
    lim = longint'(1) <<< (n - 1);
    e.q = '0; e.r = '0; e.err = 1'b0; e.lat = n + 2; e.start = 0; e.tag = "";
    if (vm == 0 || (dm / vm) >= (lim * 2)) begin
      e.err = 1'b1;
      e.lat = 2;
    end else begin
      q = d / v;
      r = d % v;
      if (s && (q > lim - 1 || q < -lim)) e.err = 1'b1;
      else begin
        e.q = w ? 16'(q) : {8'h00, 8'(q)};
        e.r = w ? 16'(r) : {8'h00, 8'(r)};
      end
    end
    return e;
  endfunction

  // ce pattern: always on, or one cycle in three
  initial begin
    int ph;
    ph = 0;
    ce = 1'b1;
    forever begin
      @(negedge clk);
      if (ce_mode != 0) begin
        ph = (ph + 1) % 3;
        ce = (ph == 0);
      end else ce = 1'b1;
    end
  end

  // Monitor: compare each done pulse against the oldest expectation
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, required no done");
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, " quot"}, 32'(quot), 32'(mon_e.q));
        chk({mon_e.tag, " rem"}, 32'(rem), 32'(mon_e.r));
        chk({mon_e.tag, " div_error"}, 32'(div_error), 32'(mon_e.err));
        chk({mon_e.tag, " latency"}, cecnt - mon_e.start + 1, mon_e.lat);
        chk({mon_e.tag, " busy_at_done"}, 32'(busy), 32'd0);
      end
    end
    done_q = done;
  end

  task automatic issue(input logic w, input logic s, input logic [31:0] dvd,
                       input logic [15:0] dvs, input string tag, output int unsigned lat);
    exp_t e;
    int   g;
    lat = 0;
    g = 0;
    @(negedge clk);
    while ((busy || done) && g < 500) begin @(negedge clk); g++; end
    op_wide = w; op_signed = s; dividend = dvd; divisor = dvs; req = 1'b1;
    g = 0;
    do begin @(negedge clk); g++; end while (!busy && g < 60);
    req = 1'b0;
    if (!busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s accept: got busy=0, required busy=1", tag);
      return;
    end
    e = model(w, s, dvd, dvs);
    e.start = cecnt;
    e.tag = tag;
    sb.push_back(e);
    lat = e.lat;
    // operands must be latched: scramble them right after acceptance
    dividend = $urandom; divisor = 16'($urandom);
    op_wide = 1'($urandom); op_signed = 1'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 1000) begin @(negedge clk); g++; end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic rand_op(input string tag, input bit pulse);
    logic [31:0] dvd;
    logic [15:0] dvs;
    int unsigned lat;
    dvd = $urandom;
    if ($urandom_range(0, 1) == 1) dvd = dvd >> $urandom_range(0, 24);
    dvs = 16'($urandom);
    if ($urandom_range(0, 2) == 0) dvs = dvs >> $urandom_range(0, 15);
    issue(1'($urandom), 1'($urandom), dvd, dvs, tag, lat);
    if (pulse && lat > 2) begin
      repeat (5) @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
    end
    drain();
  endtask

  initial begin
    int unsigned lat;
    #(1000000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat;
    reset_n = 1'b0; req = 1'b0; op_wide = 1'b0; op_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset div_error", 32'(div_error), 0);
    chk("reset quot", 32'(quot), 0);
    chk("reset rem", 32'(rem), 0);
    reset_n = 1'b1;

    issue(1, 0, 32'h00012345, 16'h0010, "u_word", lat); drain();
    issue(0, 1, 32'h0000FFF9, 16'h0002, "s_byte", lat); drain();
    issue(1, 0, 32'hDEADBEEF, 16'h0000, "dz_word_u", lat); drain();
    issue(1, 1, 32'h00001234, 16'h0000, "dz_word_s", lat); drain();
    issue(1, 0, 32'h00100000, 16'h0010, "u_ovf", lat); drain();
    issue(1, 1, 32'hFFFF8000, 16'h0001, "s_min_ok", lat); drain();
    issue(1, 1, 32'h00008000, 16'h0001, "s_pos_ovf", lat); drain();
    issue(1, 1, 32'h00008000, 16'hFFFF, "s_neg_min", lat); drain();
    issue(1, 1, 32'h80000000, 16'hFFFF, "s_prep_ovf", lat); drain();
    issue(1, 0, 32'hFFFEFFFF, 16'hFFFF, "u_word_max", lat); drain();
    issue(0, 1, 32'h0000FF80, 16'h0001, "sb_min_ok", lat); drain();
    issue(0, 1, 32'h00000080, 16'h0001, "sb_pos_ovf", lat); drain();
    issue(0, 1, 32'h00000080, 16'h00FF, "sb_neg_min", lat); drain();
    issue(0, 0, 32'h00000100, 16'h0001, "ub_ovf", lat); drain();
    issue(0, 1, 32'h0000FF85, 16'h00FD, "sb_negneg", lat); drain();

    // req pulsed while the operation is running must not start another
    issue(1, 0, 32'h00012345, 16'h0010, "pulse_mid", lat);
    repeat (5) @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    drain();

    ce_mode = 1;
    issue(1, 0, 32'h00012345, 16'h0010, "ce3_u_word", lat); drain();
    issue(0, 1, 32'h0000FFF9, 16'h0002, "ce3_s_byte", lat); drain();
    issue(1, 0, 32'h00000005, 16'h0000, "ce3_dz", lat); drain();
    for (int i = 0; i < 12; i++) rand_op($sformatf("ce3_rand%0d", i), i % 3 == 0);
    ce_mode = 0;
    for (int i = 0; i < 30; i++) rand_op($sformatf("rand%0d", i), i % 4 == 0);

    // reset in the middle of RUN aborts without a done pulse
    issue(1, 0, 32'h00012345, 16'h0010, "reset_mid", lat);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("reset_mid busy", 32'(busy), 0);
    chk("reset_mid done", 32'(done), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    issue(1, 1, 32'hFFFFF000, 16'h0030, "after_reset", lat); drain();

    repeat (40) @(negedge clk);
    chk("final_pending", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
